// File: rtl/fifo_bram_sync_if.sv
// Stream port bundle for fifo_bram_sync: write side, read side and status.
// master = producer/consumer logic driving requests; slave = the FIFO itself.
interface fifo_bram_sync_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 10
);
  logic              wr_en;
  logic [WIDTH-1:0]  din;
  logic              wr_full;
  logic              wr_almost_full;
  logic              overflow;
  logic              rd_en;
  logic [WIDTH-1:0]  dout;
  logic              dout_valid;
  logic              rd_empty;
  logic              rd_almost_empty;
  logic              underflow;
  logic [ADDR_W:0]   data_count;

  modport master (
    output wr_en, din, rd_en,
    input  wr_full, wr_almost_full, overflow,
    input  dout, dout_valid, rd_empty, rd_almost_empty, underflow, data_count
  );

  modport slave (
    input  wr_en, din, rd_en,
    output wr_full, wr_almost_full, overflow,
    output dout, dout_valid, rd_empty, rd_almost_empty, underflow, data_count
  );
endinterface

// File: rtl/fifo_bram_sync.sv
// Single-clock FIFO on inferred block RAM. Standard mode returns data the
// cycle after rd_en; FWFT mode keeps the head word presented on dout.
// A separate occupancy counter drives all flags, so no pointer-compare tricks.
module fifo_bram_sync #(
  parameter int WIDTH         = 32,
  parameter int ADDR_W        = 10,
  parameter int FWFT          = 0,
  parameter int AFULL_THRESH  = 2**ADDR_W - 4,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic              clk,
  input  logic              rst,
  fifo_bram_sync_if.slave   fifo
);

  localparam int              DEPTH   = 2**ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   count, count_next, unread;
  logic              wr_full, wr_almost_full, overflow;
  logic              rd_empty, rd_almost_empty, underflow, rd_empty_next;
  logic              wr_acc, rd_acc, ram_rd;
  // FWFT pipeline: stage a is the RAM output register, stage b is dout.
  logic              a_valid, b_valid, a_valid_next, b_valid_next, a_to_b;
  logic              std_valid;
  logic [WIDTH-1:0]  ram_q, out_q;

  // Accept decisions, next occupancy and read-pipeline movement.
  always_comb begin
    // NOTE: every signal gets a default here, so no path leaves one unassigned and no latch is inferred.
    wr_acc        = fifo.wr_en & ~wr_full;
    rd_acc        = fifo.rd_en & ~rd_empty;
    count_next    = count + {{ADDR_W{1'b0}}, wr_acc} - {{ADDR_W{1'b0}}, rd_acc};
    unread        = count - {{ADDR_W{1'b0}}, a_valid} - {{ADDR_W{1'b0}}, b_valid};
    a_to_b        = 1'b0;
    ram_rd        = rd_acc;
    a_valid_next  = 1'b0;
    b_valid_next  = 1'b0;
    rd_empty_next = (count_next == '0);
    if (FWFT != 0) begin
      // Head word moves to dout when dout is free or being popped; the RAM
      // refills stage a whenever it holds an unread word and a is draining.
      a_to_b        = a_valid & (~b_valid | rd_acc);
      ram_rd        = (unread != '0) & (~a_valid | a_to_b);
      a_valid_next  = ram_rd | (a_valid & ~a_to_b);
      b_valid_next  = a_to_b | (b_valid & ~rd_acc);
      rd_empty_next = ~b_valid_next;
    end
  end

  // RAM write port.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset so it maps onto block RAM; stale words are unreachable after reset.
    if (wr_acc && !rst) mem[wr_ptr] <= fifo.din;
  end

  // RAM read port with its registered output.
  always_ff @(posedge clk) begin
    if (rst)         ram_q <= '0;
    else if (ram_rd) ram_q <= mem[rd_ptr];
  end

  // Pointers, occupancy, flags, error pulses and the FWFT output stage.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
    if (rst) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      wr_full         <= 1'b0;
      wr_almost_full  <= (AFULL_THRESH == 0);
      overflow        <= 1'b0;
      rd_empty        <= 1'b1;
      rd_almost_empty <= 1'b1;
      underflow       <= 1'b0;
      a_valid         <= 1'b0;
      b_valid         <= 1'b0;
      std_valid       <= 1'b0;
      out_q           <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (ram_rd) rd_ptr <= rd_ptr + ADDR_W'(1);
      count           <= count_next;
      wr_full         <= (count_next == DEPTH_C);
      wr_almost_full  <= (int'(count_next) >= AFULL_THRESH);
      rd_almost_empty <= (int'(count_next) <= AEMPTY_THRESH);
      rd_empty        <= rd_empty_next;
      overflow        <= fifo.wr_en & wr_full;
      underflow       <= fifo.rd_en & rd_empty;
      a_valid         <= a_valid_next;
      b_valid         <= b_valid_next;
      std_valid       <= (FWFT == 0) & rd_acc;
      if (a_to_b) out_q <= ram_q;
    end
  end

  assign fifo.wr_full         = wr_full;
  assign fifo.wr_almost_full  = wr_almost_full;
  assign fifo.overflow        = overflow;
  assign fifo.rd_empty        = rd_empty;
  assign fifo.rd_almost_empty = rd_almost_empty;
  assign fifo.underflow       = underflow;
  assign fifo.data_count      = count;
  assign fifo.dout            = (FWFT != 0) ? out_q   : ram_q;
  assign fifo.dout_valid      = (FWFT != 0) ? b_valid : std_valid;

endmodule

// File: tb/tb_fifo_bram_sync.sv
// Bench for fifo_bram_sync: four instances (16/1024 deep, standard/FWFT) run
// on shared stimulus and are compared every cycle against a queue model
// plus directed checks for the fill/drain, wrap, full-with-read and FWFT cases.
module tb_fifo_bram_sync;

  logic        clk = 1'b0;
  logic        rst, wr_en, rd_en;
  logic [31:0] din;

  always #5 clk = ~clk;

  fifo_bram_sync_if #(.WIDTH(8),  .ADDR_W(4))  if_s4 ();
  fifo_bram_sync_if #(.WIDTH(8),  .ADDR_W(4))  if_f4 ();
  fifo_bram_sync_if #(.WIDTH(32), .ADDR_W(10)) if_s10 ();
  fifo_bram_sync_if #(.WIDTH(32), .ADDR_W(10)) if_f10 ();

  assign if_s4.wr_en  = wr_en; assign if_s4.rd_en  = rd_en; assign if_s4.din  = din[7:0];
  assign if_f4.wr_en  = wr_en; assign if_f4.rd_en  = rd_en; assign if_f4.din  = din[7:0];
  assign if_s10.wr_en = wr_en; assign if_s10.rd_en = rd_en; assign if_s10.din = din;
  assign if_f10.wr_en = wr_en; assign if_f10.rd_en = rd_en; assign if_f10.din = din;

  fifo_bram_sync #(.WIDTH(8),  .ADDR_W(4),  .FWFT(0)) u_s4  (.clk(clk), .rst(rst), .fifo(if_s4));
  fifo_bram_sync #(.WIDTH(8),  .ADDR_W(4),  .FWFT(1)) u_f4  (.clk(clk), .rst(rst), .fifo(if_f4));
  fifo_bram_sync #(.WIDTH(32), .ADDR_W(10), .FWFT(0)) u_s10 (.clk(clk), .rst(rst), .fifo(if_s10));
  fifo_bram_sync #(.WIDTH(32), .ADDR_W(10), .FWFT(1)) u_f10 (.clk(clk), .rst(rst), .fifo(if_f10));

  // Observed outputs gathered into arrays indexed by instance.
  logic [31:0] o_dout [4];
  logic [10:0] o_cnt  [4];
  logic        o_full [4], o_af [4], o_ae [4], o_emp [4], o_ov [4], o_un [4], o_dv [4];

  assign o_dout[0] = 32'(if_s4.dout);  assign o_cnt[0] = 11'(if_s4.data_count);
  assign o_dout[1] = 32'(if_f4.dout);  assign o_cnt[1] = 11'(if_f4.data_count);
  assign o_dout[2] = if_s10.dout;      assign o_cnt[2] = if_s10.data_count;
  assign o_dout[3] = if_f10.dout;      assign o_cnt[3] = if_f10.data_count;
  assign o_full[0] = if_s4.wr_full;  assign o_af[0] = if_s4.wr_almost_full;  assign o_ae[0] = if_s4.rd_almost_empty;
  assign o_full[1] = if_f4.wr_full;  assign o_af[1] = if_f4.wr_almost_full;  assign o_ae[1] = if_f4.rd_almost_empty;
  assign o_full[2] = if_s10.wr_full; assign o_af[2] = if_s10.wr_almost_full; assign o_ae[2] = if_s10.rd_almost_empty;
  assign o_full[3] = if_f10.wr_full; assign o_af[3] = if_f10.wr_almost_full; assign o_ae[3] = if_f10.rd_almost_empty;
  assign o_emp[0] = if_s4.rd_empty;  assign o_ov[0] = if_s4.overflow;  assign o_un[0] = if_s4.underflow;  assign o_dv[0] = if_s4.dout_valid;
  assign o_emp[1] = if_f4.rd_empty;  assign o_ov[1] = if_f4.overflow;  assign o_un[1] = if_f4.underflow;  assign o_dv[1] = if_f4.dout_valid;
  assign o_emp[2] = if_s10.rd_empty; assign o_ov[2] = if_s10.overflow; assign o_un[2] = if_s10.underflow; assign o_dv[2] = if_s10.dout_valid;
  assign o_emp[3] = if_f10.rd_empty; assign o_ov[3] = if_f10.overflow; assign o_un[3] = if_f10.underflow; assign o_dv[3] = if_f10.dout_valid;

  // Reference model: a circular queue per instance plus the write time of
  // each word; in FWFT mode a stored word is presented two edges after its write.
  int          m_depth [4] = '{16, 16, 1024, 1024};
  bit          m_fw    [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  int          m_af    [4] = '{12, 12, 1020, 1020};
  int          m_ae    [4] = '{4, 4, 4, 4};
  logic [31:0] m_mask  [4] = '{32'hFF, 32'hFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
  string       m_name  [4] = '{"s4", "f4", "s10", "f10"};
  logic [31:0] m_data  [4][1024];
  int          m_wt    [4][1024];
  int          m_head  [4], m_size [4];
  logic [31:0] m_dout  [4];
  bit          m_dv [4], m_ov [4], m_un [4], m_vis [4];
  int          cyc;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Advance the model by one clock edge using the inputs sampled at that edge.
  task automatic model_edge();
    for (int i = 0; i < 4; i++) begin
      if (rst) begin
        m_size[i] = 0; m_head[i] = 0; m_dout[i] = '0;
        m_dv[i] = 1'b0; m_ov[i] = 1'b0; m_un[i] = 1'b0; m_vis[i] = 1'b0;
      end else begin
        bit full, empty, wa, ra;
        full  = (m_size[i] == m_depth[i]);
        empty = m_fw[i] ? !m_vis[i] : (m_size[i] == 0);
        wa = wr_en && !full;
        ra = rd_en && !empty;
        m_ov[i] = wr_en && full;
        m_un[i] = rd_en && empty;
        if (ra) begin
          if (!m_fw[i]) m_dout[i] = m_data[i][m_head[i]];
          m_head[i] = (m_head[i] + 1) % m_depth[i];
          m_size[i]--;
        end
        if (!m_fw[i]) m_dv[i] = ra;
        if (wa) begin
          m_data[i][(m_head[i] + m_size[i]) % m_depth[i]] = din & m_mask[i];
          m_wt[i][(m_head[i] + m_size[i]) % m_depth[i]]   = cyc;
          m_size[i]++;
        end
        if (m_fw[i]) begin
          m_vis[i] = (m_size[i] > 0) && (cyc - m_wt[i][m_head[i]] >= 2);
          m_dv[i]  = m_vis[i];
          if (m_vis[i]) m_dout[i] = m_data[i][m_head[i]];
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 4; i++) begin
      check({m_name[i], ".data_count"},      32'(o_cnt[i]),  32'(m_size[i]));
      check({m_name[i], ".wr_full"},         32'(o_full[i]), 32'(m_size[i] == m_depth[i]));
      check({m_name[i], ".wr_almost_full"},  32'(o_af[i]),   32'(m_size[i] >= m_af[i]));
      check({m_name[i], ".rd_almost_empty"}, 32'(o_ae[i]),   32'(m_size[i] <= m_ae[i]));
      check({m_name[i], ".rd_empty"},        32'(o_emp[i]),  32'(m_fw[i] ? !m_vis[i] : (m_size[i] == 0)));
      check({m_name[i], ".overflow"},        32'(o_ov[i]),   32'(m_ov[i]));
      check({m_name[i], ".underflow"},       32'(o_un[i]),   32'(m_un[i]));
      check({m_name[i], ".dout_valid"},      32'(o_dv[i]),   32'(m_dv[i]));
      if (!m_fw[i] || m_vis[i])
        check({m_name[i], ".dout"},          o_dout[i],      m_dout[i]);
    end
  endtask

  // One clock: model follows the edge, outputs sampled 1 ns later.
  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic drive(input logic r, input logic w, input logic rd, input logic [31:0] d);
    rst = r; wr_en = w; rd_en = rd; din = d;
  endtask

  initial begin
    int wp, rp;
    logic [31:0] seq;
    cyc = 0;
    drive(1'b1, 1'b1, 1'b1, $urandom);

    // Reset held with both requests active.
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'b1, 1'b1, $urandom);
      step();
    end
    check("reset.rd_empty",   32'(o_emp[0]), 32'd1);
    check("reset.wr_full",    32'(o_full[0]), 32'd0);
    check("reset.data_count", 32'(o_cnt[0]), 32'd0);
    check("reset.dout",       o_dout[0], 32'd0);
    check("reset.dout_valid", 32'(o_dv[0]), 32'd0);
    check("reset.ovf_unf",    32'({o_ov[0], o_un[0]}), 32'd0);

    // Fill 0..15, then one write too many.
    for (int k = 0; k < 16; k++) begin
      drive(1'b0, 1'b1, 1'b0, 32'(k));
      step();
      if (k == 10) check("fill.afull_at_11", 32'(o_af[0]), 32'd0);
      if (k == 11) check("fill.afull_at_12", 32'(o_af[0]), 32'd1);
    end
    check("fill.count16", 32'(o_cnt[0]), 32'd16);
    check("fill.full",    32'(o_full[0]), 32'd1);
    drive(1'b0, 1'b1, 1'b0, 32'd16);
    step();
    check("fill.overflow_pulse", 32'(o_ov[0]), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 32'd0);
    step();
    check("fill.overflow_one_cycle", 32'(o_ov[0]), 32'd0);
    check("fill.count_after_reject", 32'(o_cnt[0]), 32'd16);

    // Drain 16 in order, then one read too many.
    for (int k = 0; k < 16; k++) begin
      drive(1'b0, 1'b0, 1'b1, 32'd0);
      step();
      check("drain.dout", o_dout[0], 32'(k));
      if (k == 11) check("drain.aempty_at_4", 32'(o_ae[0]), 32'd1);
    end
    check("drain.empty", 32'(o_emp[0]), 32'd1);
    step();
    check("drain.underflow_pulse", 32'(o_un[0]), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 32'd0);
    step();
    check("drain.underflow_one_cycle", 32'(o_un[0]), 32'd0);

    // Wrap: hold 8 words while streaming 100 cycles of write+read.
    drive(1'b1, 1'b0, 1'b0, 32'd0);
    step();
    seq = 0;
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 1'b1, 1'b0, seq);
      seq++;
      step();
    end
    for (int k = 0; k < 100; k++) begin
      drive(1'b0, 1'b1, 1'b1, seq);
      seq++;
      step();
      check("wrap.dout", o_dout[0], 32'(k) & 32'hFF);
    end
    check("wrap.count8", 32'(o_cnt[0]), 32'd8);

    // Full with simultaneous read.
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 1'b1, 1'b0, seq);
      seq++;
      step();
    end
    check("fullrd.count16", 32'(o_cnt[0]), 32'd16);
    drive(1'b0, 1'b1, 1'b1, seq);
    step();
    check("fullrd.overflow",   32'(o_ov[0]), 32'd1);
    check("fullrd.read_valid", 32'(o_dv[0]), 32'd1);
    check("fullrd.count15",    32'(o_cnt[0]), 32'd15);

    // FWFT single word latency.
    drive(1'b1, 1'b0, 1'b0, 32'd0);
    step();
    drive(1'b0, 1'b1, 1'b0, 32'hA5);
    step();
    check("fwft.count_after_write", 32'(o_cnt[1]), 32'd1);
    check("fwft.empty_plus1",       32'(o_emp[1]), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 32'd0);
    step();
    check("fwft.empty_plus2",       32'(o_emp[1]), 32'd1);
    step();
    check("fwft.not_empty",         32'(o_emp[1]), 32'd0);
    check("fwft.dout_a5",           o_dout[1], 32'hA5);
    drive(1'b0, 1'b0, 1'b1, 32'd0);
    step();
    drive(1'b0, 1'b0, 1'b0, 32'd0);
    check("fwft.empty_after_pop",   32'(o_emp[1]), 32'd1);
    check("fwft.count_after_pop",   32'(o_cnt[1]), 32'd0);

    // Random soak with alternating write-heavy / read-heavy phases.
    drive(1'b1, 1'b0, 1'b0, 32'd0);
    step();
    seq = 0;
    for (int n = 0; n < 20000 && fails == 0; n++) begin
      if ((n / 4000) % 2 == 0) begin wp = 80; rp = 30; end
      else                     begin wp = 30; rp = 80; end
      wr_en = ($urandom_range(0, 99) < wp) && (o_cnt[2][10:4] != 7'h7F);
      rd_en = ($urandom_range(0, 99) < rp);
      din   = seq;
      rst   = 1'b0;
      if (wr_en) seq++;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
